ihp13_sram_bist: RTL and testbench

IHP13_SRAM_BIST -- requirements
Module: ihp13_sram_bist

---
 rtl/ihp13_sram_bist.sv | 179 +++++++++++++++++
 tb/tb_ihp13_sram_bist.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ihp13_sram_bist.sv
// March C- BIST controller for an IHP 130nm SRAM macro, driving its A_BIST_* port.
// Define IHP13_SRAM_BIST_ABORT_ON_FAIL_EN to stop the test at the first mismatch.
module ihp13_sram_bist #(
  parameter  int unsigned NumWords     = 256,
  parameter  int unsigned DataWidth    = 64,
  parameter  int unsigned FailCntWidth = 16,
  localparam int unsigned AddrWidth    = $clog2(NumWords)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic                    bist_en_o,
  output logic                    bist_clk_o,
  output logic [AddrWidth-1:0]    bist_addr_o,
  output logic [DataWidth-1:0]    bist_din_o,
  output logic [DataWidth-1:0]    bist_bm_o,
  output logic                    bist_men_o,
  output logic                    bist_wen_o,
  output logic                    bist_ren_o,
  input  logic [DataWidth-1:0]    bist_dout_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_DRAIN, S_DONE
  } state_e;

  localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(NumWords - 1);

  function automatic logic is_access(input state_e s);
    return (s == S_E0) || (s == S_E1) || (s == S_E2) ||
           (s == S_E3) || (s == S_E4) || (s == S_E5);
  endfunction

  function automatic logic is_two_cycle(input state_e s);
    return (s == S_E1) || (s == S_E2) || (s == S_E3) || (s == S_E4);
  endfunction

  function automatic logic is_down(input state_e s);
    return (s == S_E3) || (s == S_E4);
  endfunction

  function automatic logic [FailCntWidth-1:0] sat_inc(input logic [FailCntWidth-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e                 state_q, state_n;
  logic [AddrWidth-1:0]   addr_q, addr_n;
  logic                   phase_q, phase_n;   // 0: read cycle, 1: write cycle (E1..E4)
  logic                   last_addr;
  logic                   start_acc;
  logic                   mismatch;
  logic                   men_n, wen_n, ren_n, busy_n;

  logic                   rd_vld_p1;
  logic                   exp_one_p1;
  logic [AddrWidth-1:0]   addr_p1;

  assign bist_clk_o = clk_i;
  assign last_addr  = is_down(state_q) ? (addr_q == '0) : (addr_q == AddrLast);
  assign start_acc  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mismatch   = rd_vld_p1 && (bist_dout_i != {DataWidth{exp_one_p1}});

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    phase_n = phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n = S_E0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      S_E0, S_E5: begin
        if (last_addr) begin
          state_n = (state_q == S_E0) ? S_E1 : S_DRAIN;
          addr_n  = '0;
        end else begin
          addr_n = addr_q + 1'b1;
        end
      end
      S_E1, S_E2, S_E3, S_E4: begin
        if (!phase_q) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (last_addr) begin
            case (state_q)
              S_E1:    state_n = S_E2;
              S_E2:    state_n = S_E3;
              S_E3:    state_n = S_E4;
              default: state_n = S_E5;
            endcase
            // E3 and E4 sweep downwards, so they start from the top address
            addr_n = ((state_q == S_E2) || (state_q == S_E3)) ? AddrLast : '0;
          end else begin
            addr_n = is_down(state_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
`ifdef IHP13_SRAM_BIST_ABORT_ON_FAIL_EN
    if (mismatch) state_n = S_DONE;
`endif
  end

  assign men_n  = is_access(state_n);
  assign wen_n  = (state_n == S_E0) || (is_two_cycle(state_n) && phase_n);
  assign ren_n  = (state_n == S_E5) || (is_two_cycle(state_n) && !phase_n);
  assign busy_n = men_n || (state_n == S_DRAIN);

  // Stage p0: FSM state and registered macro access for the next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      bist_en_o   <= 1'b0;
      bist_addr_o <= '0;
      bist_din_o  <= '0;
      bist_bm_o   <= '0;
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      phase_q     <= phase_n;
      busy_o      <= busy_n;
      done_o      <= (state_n == S_DONE);
      bist_en_o   <= busy_n;
      bist_addr_o <= men_n ? addr_n : '0;
      bist_din_o  <= {DataWidth{wen_n && ((state_n == S_E1) || (state_n == S_E3))}};
      bist_bm_o   <= {DataWidth{busy_n}};
      bist_men_o  <= men_n;
      bist_wen_o  <= wen_n;
      bist_ren_o  <= ren_n;
    end
  end

  // Stage p1: read issued last cycle, its data is compared this cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= bist_ren_o && (state_n != S_DONE);
    end
    exp_one_p1 <= (state_q == S_E2) || (state_q == S_E4);
    addr_p1    <= bist_addr_o;
  end

  // Stage p2: sticky failure status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_cnt_o  <= '0;
    end else if (start_acc) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_cnt_o  <= '0;
    end else if (mismatch) begin
      fail_o     <= 1'b1;
      fail_cnt_o <= sat_inc(fail_cnt_o);
      if (!fail_o) fail_addr_o <= addr_p1;
    end
  end

endmodule

// File: tb/tb_ihp13_sram_bist.sv
// Directed bench for ihp13_sram_bist: ideal macro, stuck-at fault, mid-test reset,
// ignored start while busy, and a 2-word instance for the address sequence.
module tb_ihp13_sram_bist;
  localparam int NW = 256, DW = 64, FW = 16, AW = 8;
  localparam int NW2 = 2, DW2 = 8, AW2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, fault_en;
  logic          busy, done, fail, en, bclk, men, wen, ren;
  logic [AW-1:0] fail_addr, baddr;
  logic [FW-1:0] fail_cnt;
  logic [DW-1:0] din, bm, dout;
  logic [DW-1:0] mem [NW];

  logic           rst2, start2;
  logic           busy2, done2, fail2, en2, bclk2, men2, wen2, ren2;
  logic [AW2-1:0] fail_addr2, baddr2;
  logic [FW-1:0]  fail_cnt2;
  logic [DW2-1:0] din2, bm2, dout2;
  logic [DW2-1:0] mem2 [NW2];

  ihp13_sram_bist #(.NumWords(NW), .DataWidth(DW), .FailCntWidth(FW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .fail_o(fail), .fail_addr_o(fail_addr), .fail_cnt_o(fail_cnt),
    .bist_en_o(en), .bist_clk_o(bclk), .bist_addr_o(baddr), .bist_din_o(din),
    .bist_bm_o(bm), .bist_men_o(men), .bist_wen_o(wen), .bist_ren_o(ren),
    .bist_dout_i(dout)
  );

  ihp13_sram_bist #(.NumWords(NW2), .DataWidth(DW2), .FailCntWidth(FW)) dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .fail_o(fail2), .fail_addr_o(fail_addr2), .fail_cnt_o(fail_cnt2),
    .bist_en_o(en2), .bist_clk_o(bclk2), .bist_addr_o(baddr2), .bist_din_o(din2),
    .bist_bm_o(bm2), .bist_men_o(men2), .bist_wen_o(wen2), .bist_ren_o(ren2),
    .bist_dout_i(dout2)
  );

  // Synchronous macro models; bit 5 of word 0x3A reads as 1 when the fault is enabled
  always @(posedge clk) begin
    if (men) begin
      if (wen) mem[baddr] <= (din & bm) | (mem[baddr] & ~bm);
      if (ren) dout <= mem[baddr] | ((fault_en && baddr == 8'h3A) ? 64'h20 : 64'h0);
    end
  end

  always @(posedge clk) begin
    if (men2) begin
      if (wen2) mem2[baddr2] <= (din2 & bm2) | (mem2[baddr2] & ~bm2);
      if (ren2) dout2 <= mem2[baddr2];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start, then counts busy cycles; optionally re-pulses start at cycle pulse_at
  task automatic run_dut(input int pulse_at, output int busy_cyc, output int men_cyc,
                         output int proto_err, output logic [2:0] first_flags);
    busy_cyc = 0; men_cyc = 0; proto_err = 0; first_flags = 3'b111;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy === 1'b1 && busy_cyc < 20000) begin
      busy_cyc++;
      if (busy_cyc == 1) first_flags = {done, fail, |fail_cnt};
      if (men === 1'b1) begin
        men_cyc++;
        if ((wen ^ ren) !== 1'b1 || bm !== {DW{1'b1}}) proto_err++;
      end else if ((wen | ren) !== 1'b0) begin
        proto_err++;
      end
      if (en !== 1'b1) proto_err++;
      start = (busy_cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int         bc, mc, pe;
  logic [2:0] ff;
  int         addr_q2[$];
  int         exp_seq2[20] = '{0,1, 0,0,1,1, 0,0,1,1, 1,1,0,0, 1,1,0,0, 0,1};

  initial begin
    rst = 1'b1; start = 1'b0; fault_en = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {busy, done, fail, en, men, wen, ren}, 0);
    check_eq("rst_fail_addr", fail_addr, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    check_eq("rst_addr", baddr, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_bm", bm, 0);
    check_eq("bist_clk_low", bclk, 0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // Ideal macro: 10*256+1 busy cycles, 2560 accesses
    run_dut(0, bc, mc, pe, ff);
    check_eq("ideal_busy", bc, 2561);
    check_eq("ideal_men", mc, 2560);
    check_eq("ideal_proto", pe, 0);
    check_eq("ideal_done", done, 1);
    check_eq("ideal_fail", fail, 0);
    check_eq("ideal_cnt", fail_cnt, 0);
    check_eq("idle_outs", {en, men, wen, ren, bm[0]}, 0);

    // Stuck-at-1 on bit 5 of 0x3A: the r0 reads of E1, E3, E5 miss
    fault_en = 1'b1;
    run_dut(0, bc, mc, pe, ff);
`ifdef IHP13_SRAM_BIST_ABORT_ON_FAIL_EN
    // E0 takes 256 cycles; E1 read of 0x3A is cycle 257+2*0x3A, compared in the next
    check_eq("abort_busy", bc, NW + 2 * 'h3A + 2);
    check_eq("abort_cnt", fail_cnt, 1);
`else
    check_eq("fault_busy", bc, 2561);
    check_eq("fault_cnt", fail_cnt, 3);
`endif
    check_eq("fault_done", done, 1);
    check_eq("fault_fail", fail, 1);
    check_eq("fault_addr", fail_addr, 8'h3A);
    fault_en = 1'b0;

    // Restart from DONE clears sticky flags; start at cycle 500 is ignored
    run_dut(500, bc, mc, pe, ff);
    check_eq("restart_clear", ff, 0);
    check_eq("restart_busy", bc, 2561);
    check_eq("restart_fail", fail, 0);

    // Reset in cycle 1000 of a running test
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (999) @(negedge clk);
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ctrl", {busy, done, fail, en, men, wen, ren}, 0);
    check_eq("midrst_data", {baddr, fail_addr, fail_cnt}, 0);
    check_eq("midrst_din_bm", din | bm, 0);
    rst = 1'b0;
    @(negedge clk);
    run_dut(0, bc, mc, pe, ff);
    check_eq("rerun_busy", bc, 2561);
    check_eq("rerun_done", done, 1);
    check_eq("rerun_fail", {fail, fail_cnt}, 0);

    // Two-word instance: full address sequence
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    bc = 0;
    while (busy2 === 1'b1 && bc < 100) begin
      bc++;
      if (men2 === 1'b1) addr_q2.push_back(int'(baddr2));
      @(negedge clk);
    end
    check_eq("nw2_busy", bc, 21);
    check_eq("nw2_len", addr_q2.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < addr_q2.size()) check_eq($sformatf("nw2_addr%0d", i), addr_q2[i], exp_seq2[i]);
    end
    check_eq("nw2_done_fail", {done2, fail2}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
